// File: rtl/conv_mac_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_mac_ctrl : multiply-accumulate controller for one convolution job.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+

module conv_mac_mul16 (
  input  logic signed [15:0] i_a,
  input  logic signed [15:0] i_b,
  output logic signed [31:0] o_p
);
  assign o_p = i_a * i_b;
endmodule

module conv_mac_ctrl #(
  parameter int TAPS  = 9,
  parameter int ACC_W = 36
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      pixel,
  input  logic [15:0]      weight,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] result,
  output logic             overflow,
  output logic             busy
);
  localparam int               CNT_W  = 8;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic signed [31:0] r_prod;
  logic               r_prod_vld;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_result;
  logic               r_ovf;
  logic               r_in_ready;
  logic               r_res_valid;
  logic               r_busy;

  logic signed [31:0] w_prod;
  logic [ACC_W-1:0]   w_addend;
  logic [ACC_W-1:0]   w_sum;
  logic               w_add_ovf;
  logic               w_hs;

  conv_mac_mul16 u_mul (
    .i_a (pixel),
    .i_b (weight),
    .o_p (w_prod)
  );

  assign w_hs      = in_valid & r_in_ready;
  assign w_addend  = ACC_W'(r_prod);
  assign w_sum     = r_acc + w_addend;
  // Overflow: both addends share a sign that the wrapped sum does not.
  assign w_add_ovf = (r_acc[ACC_W-1] == w_addend[ACC_W-1]) &&
                     (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_prod      <= '0;
      r_prod_vld  <= 1'b0;
      r_acc       <= '0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (abort && (r_state != S_IDLE)) begin
      r_state     <= S_IDLE;
      r_prod_vld  <= 1'b0;
      r_in_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (r_prod_vld) begin
        r_acc <= w_sum;
        if (w_add_ovf) r_ovf <= 1'b1;
      end
      r_prod_vld <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_result   <= '0;
            r_state    <= S_LOAD;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_hs) begin
            r_prod     <= w_prod;
            r_prod_vld <= 1'b1;
            r_cnt      <= r_cnt + 1'b1;
            if (r_cnt == C_LAST) begin
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          r_state <= S_DONE;
        end
        S_DONE: begin
          // First DONE cycle publishes the settled accumulator.
          if (!r_res_valid) begin
            r_result    <= r_acc;
            r_res_valid <= 1'b1;
          end else if (res_ready) begin
            r_state     <= S_IDLE;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign res_valid = r_res_valid;
  assign result    = r_result;
  assign overflow  = r_ovf;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_conv_mac_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_conv_mac_ctrl : scoreboard bench for conv_mac_ctrl.                   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_conv_mac_ctrl;
  localparam int TAPS   = 9;
  localparam int AW     = 36;
  localparam int TAPS_B = 3;
  localparam int AW_B   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, abort, in_valid, res_ready;
  logic [15:0]   pixel, weight;
  logic          in_ready, res_valid, overflow, busy;
  logic [AW-1:0] result;

  logic            start_b, in_valid_b, res_ready_b;
  logic [15:0]     pixel_b, weight_b;
  logic            in_ready_b, res_valid_b, overflow_b, busy_b;
  logic [AW_B-1:0] result_b;

  conv_mac_ctrl #(.TAPS(TAPS), .ACC_W(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .pixel(pixel), .weight(weight),
    .res_valid(res_valid), .res_ready(res_ready), .result(result),
    .overflow(overflow), .busy(busy)
  );

  conv_mac_ctrl #(.TAPS(TAPS_B), .ACC_W(AW_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(1'b0),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .pixel(pixel_b), .weight(weight_b),
    .res_valid(res_valid_b), .res_ready(res_ready_b), .result(result_b),
    .overflow(overflow_b), .busy(busy_b)
  );

  typedef struct packed {
    logic [AW-1:0] r;
    logic          ov;
  } exp_t;

  exp_t    exp_q[$];
  exp_t    mon_e;
  int      n_checks = 0;
  int      n_fail   = 0;
  shortint px[TAPS];
  shortint wt[TAPS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: exact integer sum of products, wrapped into ACC_W bits,
  // flagging any partial sum that leaves the signed ACC_W range.
  function automatic void model(input int n, input int aw, output longint res, output bit ov);
    longint acc, mx, mn, t, span;
    span = longint'(1) <<< aw;
    mx   = (longint'(1) <<< (aw - 1)) - 1;
    mn   = -(longint'(1) <<< (aw - 1));
    acc  = 0;
    ov   = 1'b0;
    for (int i = 0; i < n; i++) begin
      t = acc + longint'(px[i]) * longint'(wt[i]);
      if (t > mx) begin
        ov = 1'b1;
        t  = t - span;
      end else if (t < mn) begin
        ov = 1'b1;
        t  = t + span;
      end
      acc = t;
    end
    res = acc;
  endfunction

  // Monitor: every result handshake pops one expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got %0h want none", result);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_result", 64'(result), 64'(mon_e.r));
        check("sb_overflow", 64'(overflow), 64'(mon_e.ov));
      end
    end
  end

  task automatic feed(input int n, input bit bubbles, output bit ok);
    int k   = 0;
    int cyc = 0;
    bit hs;
    while (k < n && cyc < 1000) begin
      if (bubbles && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        pixel    = 16'($urandom);
        weight   = 16'($urandom);
      end else begin
        in_valid = 1'b1;
        pixel    = px[k];
        weight   = wt[k];
      end
      start = bubbles ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) k++;
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    ok       = (k == n);
    if (!ok) check("feed_timeout", 64'(k), 64'(n));
  endtask

  task automatic run_job(input bit bubbles, input int hold, input string tag);
    longint r;
    bit     ov, ok;
    exp_t   e;
    model(TAPS, AW, r, ov);
    e.r  = r[AW-1:0];
    e.ov = ov;
    exp_q.push_back(e);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    feed(TAPS, bubbles, ok);
    if (!ok) return;
    in_valid = 1'b1;
    pixel    = 16'($urandom);
    weight   = 16'($urandom);
    @(negedge clk);
    check({tag, "_in_ready_off"}, 64'(in_ready), 64'd0);
    check({tag, "_lat_k1"}, 64'(res_valid), 64'd0);
    @(negedge clk);
    check({tag, "_lat_k2_early"}, 64'(res_valid), 64'd0);
    @(negedge clk);
    check({tag, "_lat_k2"}, 64'(res_valid), 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
      check({tag, "_hold_result"}, 64'(result), 64'(e.r));
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check({tag, "_idle_res_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_idle_result_hold"}, 64'(result), 64'(e.r));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < TAPS; i++) begin
      px[i] = shortint'($urandom);
      wt[i] = shortint'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    longint rb;
    bit     ovb, ok;
    int     cyc;
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    pixel = '0; weight = '0;
    start_b = 1'b0; in_valid_b = 1'b0; res_ready_b = 1'b0; pixel_b = '0; weight_b = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_result", 64'(result), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", 64'(busy), 64'd0);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < TAPS; i++) begin px[i] = shortint'(i + 1); wt[i] = 16'sd1; end
    run_job(1'b0, 0, "ramp");
    for (int i = 0; i < TAPS; i++) begin px[i] = -16'sd32768; wt[i] = -16'sd32768; end
    run_job(1'b0, 1, "maxneg");
    rand_data();
    run_job(1'b1, 5, "bubble_hold5");
    for (int j = 0; j < 5; j++) begin
      rand_data();
      run_job(1'b1, int'($urandom_range(0, 4)), "rand");
    end

    // Abort after four accepted pairs.
    rand_data();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    feed(4, 1'b0, ok);
    abort = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    repeat (6) begin
      @(negedge clk);
      check("abort_no_res", 64'(res_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < TAPS; i++) begin px[i] = 16'sd2; wt[i] = 16'sd3; end
    run_job(1'b0, 0, "after_abort");

    // Reset while draining the last product.
    rand_data();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    feed(TAPS, 1'b0, ok);
    #2 rst_n = 1'b0;
    #1;
    check("drain_rst_result", 64'(result), 64'd0);
    check("drain_rst_busy", 64'(busy), 64'd0);
    check("drain_rst_overflow", 64'(overflow), 64'd0);
    check("drain_rst_res_valid", 64'(res_valid), 64'd0);
    check("drain_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("drain_rst_stay_idle", 64'(busy), 64'd0);
    end
    @(posedge clk);
    #1;
    rand_data();
    run_job(1'b1, 2, "post_rst");

    // Narrow accumulator: three full-scale negative products wrap.
    for (int i = 0; i < TAPS_B; i++) begin px[i] = -16'sd32768; wt[i] = -16'sd32768; end
    model(TAPS_B, AW_B, rb, ovb);
    start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    in_valid_b = 1'b1; pixel_b = 16'h8000; weight_b = 16'h8000;
    cyc = 0;
    @(negedge clk);
    while (res_valid_b !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    in_valid_b = 1'b0;
    check("b_res_valid", 64'(res_valid_b), 64'd1);
    check("b_result", 64'(result_b), 64'(rb[AW_B-1:0]));
    check("b_overflow", 64'(overflow_b), 64'(ovb));
    @(posedge clk);
    #1 res_ready_b = 1'b1;
    @(posedge clk);
    #1 res_ready_b = 1'b0;
    @(negedge clk);
    check("b_idle", 64'(busy_b), 64'd0);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/conv_mac_ctrl.md
CONV_MAC_CTRL -- requirements
Module: conv_mac_ctrl

Interface
REQ-001 Parameters SHALL be:
  TAPS, 9, number of pixel/weight pairs per job (legal 1..255)
  ACC_W, 36, accumulator/result width in bits (legal 32..48)
REQ-002 Ports SHALL be:
  clk        in   1      single clock, all state on rising edge
  rst_n      in   1      asynchronous active-low reset
  start      in   1      begin a new job (sampled in IDLE only)
  abort      in   1      synchronous job cancel
  in_valid   in   1      pixel/weight pair valid
  in_ready   out  1      controller accepts pair
  pixel      in   16     signed two's-complement operand
  weight     in   16     signed two's-complement operand
  res_valid  out  1      result available
  res_ready  in   1      consumer takes result
  result     out  ACC_W  signed accumulated sum
  overflow   out  1      sticky signed-overflow flag for current job
  busy       out  1      high in any state except IDLE
REQ-003 The block SHALL use one clock (clk) and an asynchronous active-low reset (rst_n); no other clock or reset SHALL exist.

Function
REQ-004 The product SHALL be computed by one instance of the team's 16x16 signed array multiplier (full 32-bit two's-complement product), registered into prod_reg with a prod_vld flag.
REQ-005 FSM states SHALL be IDLE, LOAD, DRAIN, DONE.
REQ-006 IDLE: in_ready=0, res_valid=0, busy=0; start=1 -> clear acc, tap counter, overflow; next state LOAD.
REQ-007 LOAD: in_ready=1; a handshake (in_valid & in_ready) at edge k SHALL load prod_reg=pixel*weight, set prod_vld, increment tap counter.
REQ-008 On the handshake that makes the accepted count equal TAPS, next state SHALL be DRAIN; in_ready SHALL be 0 from then until the next LOAD.
REQ-009 Whenever prod_vld=1 at an edge, acc SHALL update to acc + sign_extend(prod_reg, ACC_W), modulo 2^ACC_W; prod_vld SHALL clear unless a new handshake occurs at that edge.
REQ-010 Signed overflow on any accumulate (addend signs equal, sum sign differs) SHALL set overflow; it SHALL stay set until the next start or reset.
REQ-011 DRAIN SHALL last exactly one cycle; the last product is accumulated at its exit edge; next state DONE.
REQ-012 Latency: last handshake at edge k -> res_valid=1 and final result valid after edge k+2.
REQ-013 DONE: res_valid=1, result and overflow stable; res_ready=1 -> IDLE at next edge.
REQ-014 result SHALL hold its last value in IDLE until the next start clears it.
REQ-015 start SHALL be ignored outside IDLE, including start coincident with res_ready in DONE (must be re-asserted in IDLE).
REQ-016 in_valid SHALL be ignored when in_ready=0; pixel/weight are don't-care then.
REQ-017 abort=1 in any non-IDLE state SHALL force IDLE at next edge, clear prod_vld, suppress res_valid; abort has priority over all other inputs; abort in IDLE SHALL have no effect.
REQ-018 TAPS=1 SHALL take LOAD -> DRAIN after a single handshake.
REQ-019 Input bubbles (in_valid low) in LOAD SHALL not alter acc or counter.

Reset
REQ-020 rst_n=0 SHALL immediately force state IDLE, acc=0, result=0, tap counter=0, prod_reg=0, prod_vld=0, overflow=0, in_ready=0, res_valid=0, busy=0.
REQ-021 Reset asserted mid-job SHALL discard the job; no output SHALL reflect partial state after rst_n rises.
REQ-022 After rst_n rises, the block SHALL stay IDLE until start=1.

Verification
REQ-023 TAPS=9, pixels 1..9, weights all 1, no bubbles -> result=45, overflow=0, res_valid 2 edges after 9th handshake.
REQ-024 TAPS=9, ACC_W=36, nine pairs (-32768,-32768) -> result=9663676416, overflow=0.
REQ-025 ACC_W=32, TAPS=3, three pairs (-32768,-32768) -> result=-1073741824, overflow=1.
REQ-026 Random in_valid bubbles plus res_ready held low 5 cycles in DONE -> result and res_valid stable throughout; IDLE one edge after res_ready=1.
REQ-027 abort after 4 handshakes in LOAD -> IDLE next edge, in_ready=0, res_valid never 1; subsequent job with pixels 2, weights 3, TAPS=9 -> result=54.
REQ-028 rst_n=0 during DRAIN -> all outputs 0 without waiting for clk; start after release runs a clean job.
